// File: rtl/fifo_burst_reader_pkg.sv
// fifo_rd_pkg: shared types and constants for the FIFO burst reader.
//   rd_state_e  - controller states (IDLE/READ/FLUSH/DONE)
//   SKID_DEPTH  - entries in the output skid buffer
//   FIFO_RD_LAT - FIFO read latency in cycles (rd_en -> dout/valid)
package fifo_rd_pkg;
  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} rd_state_e;
  localparam int SKID_DEPTH  = 2;
  localparam int FIFO_RD_LAT = 1;
endpackage

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: command, FIFO read port and output stream of the
// burst reader bundled together.
//   master modport : the reader (drives rd_en, stream, status)
//   slave modport  : the environment (FIFO + command source + consumer)
interface fifo_burst_reader_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic              err;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_valid;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    input  start, len, fifo_empty, fifo_dout, fifo_valid, m_ready,
    output busy, done, err, fifo_rd_en, m_valid, m_data
  );
  modport slave (
    output start, len, fifo_empty, fifo_dout, fifo_valid, m_ready,
    input  busy, done, err, fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_burst_reader_skid.sv
// fifo_rd_skid: 2-entry in-order skid buffer between FIFO read data and the
// downstream stream. Entry 0 is the head and drives the stream registers.
//   push_i/data_i : word returned by the FIFO
//   pop_i         : downstream handshake (valid_o && ready)
//   valid_o/data_o: registered stream outputs
//   occ_o         : entries held (0..2)
module fifo_rd_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);
  logic [DATA_W-1:0] d0_q, d1_q;
  logic [1:0]        occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_q  <= '0;
      d1_q  <= '0;
      occ_q <= '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: if (occ_q != 2'd2) begin
          if (occ_q == 2'd0) d0_q <= data_i;
          else               d1_q <= data_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          d0_q  <= d1_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new word lands behind whatever remains
          if (occ_q == 2'd1) d0_q <= data_i;
          else begin
            d0_q <= d1_q;
            d1_q <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o = (occ_q != 2'd0);
  assign data_o  = d0_q;
  assign occ_o   = occ_q;
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains exactly len words from a 1-cycle-latency FIFO
// and streams them downstream with valid/ready, one word per cycle under
// backpressure.
//   clk, rst_n : clock, async active-low reset
//   bus        : fifo_burst_reader_if.master (command, FIFO port, stream)
// Optional: define FIFO_RD_ERR_EN to enable the sticky FIFO protocol checker
// driving err; otherwise err is tied low.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_burst_reader_if.master bus
);
  rd_state_e        state_q;
  logic [LEN_W-1:0] issue_rem_q, deliver_rem_q;
  logic             inflight_q, busy_q, done_q;
  logic             m_valid, pop, push, rd_en;
  logic [1:0]       occ;
  logic [2:0]       committed;

  assign pop  = m_valid && bus.m_ready;
  // only words we actually asked for enter the buffer
  assign push = bus.fifo_valid && inflight_q;

  // words that will sit in the skid after this cycle if no new read issues
  assign committed = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
  assign rd_en = (state_q == READ) && !bus.fifo_empty &&
                 (issue_rem_q != '0) && (int'(committed) < SKID_DEPTH);

  fifo_rd_skid #(.DATA_W(DATA_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .data_i (bus.fifo_dout),
    .pop_i  (pop),
    .valid_o(m_valid),
    .data_o (bus.m_data),
    .occ_o  (occ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      issue_rem_q   <= '0;
      deliver_rem_q <= '0;
      inflight_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      done_q     <= 1'b0;
      if (pop && deliver_rem_q != '0) deliver_rem_q <= deliver_rem_q - 1'b1;
      case (state_q)
        IDLE: if (bus.start) begin
          issue_rem_q   <= bus.len;
          deliver_rem_q <= bus.len;
          if (bus.len == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= READ;
            busy_q  <= 1'b1;
          end
        end
        READ: begin
          if (rd_en) begin
            issue_rem_q <= issue_rem_q - 1'b1;
            if (issue_rem_q == LEN_W'(1)) state_q <= FLUSH;
          end else if (issue_rem_q == '0) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: if (deliver_rem_q == '0 || (deliver_rem_q == LEN_W'(1) && pop)) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

`ifdef FIFO_RD_ERR_EN
  logic err_q;
  // a pending read must return data, and data must only come when pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_q <= 1'b0;
    else if (bus.fifo_valid != inflight_q)  err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Consumer-side controller for the 8-bit synchronous FIFO: on a start command it drains exactly `len` words from the FIFO's read port and presents them downstream as a valid/ready stream. It hides the FIFO's one-cycle read latency (`rd_en` → `dout`/`valid`) behind a 2-entry skid buffer, so throughput stays at one word per cycle under arbitrary backpressure with no loss. It sits between the FIFO instance and the accelerator datapath that consumes buffered words.

## Interface
- `DATA_W`, 8: FIFO/stream data width.
- `LEN_W`, 8: burst length width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; latches `len`, begins a burst.
- `len`  in  LEN_W  words to read this burst; sampled with `start`.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse, burst complete.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `fifo_dout`  in  DATA_W  FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_valid`  in  1  FIFO read-data valid.
- `m_valid`  out  1  downstream data valid.
- `m_ready`  in  1  downstream ready.
- `m_data`  out  DATA_W  downstream data.
- `err`  out  1  sticky protocol error (see Configuration).

## Operation
- States: IDLE, READ, FLUSH, DONE.
- IDLE: `start`=1 → latch `issue_rem`=`len`, `deliver_rem`=`len`; go READ, or DONE if `len`=0.
- READ: `fifo_rd_en` = !`fifo_empty` && `issue_rem`≠0 && (`occ` + `inflight` − `pop`) < 2, where `occ` = skid entries (0..2), `inflight` = read issued last cycle (0/1), `pop` = `m_valid` && `m_ready`. Each strobe decrements `issue_rem`. `issue_rem` reaching 0 → FLUSH.
- FLUSH: no reads; wait for `deliver_rem`=0 → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `busy`=1 in READ and FLUSH.
- A word returned with `fifo_valid` enters the skid buffer; a returned word is never dropped. Stream order equals FIFO order. `m_valid` stays high and `m_data` stays stable until accepted.
- `start` while `busy` is ignored.
- `fifo_empty` during READ: stall without strobing; resume when it deasserts. No timeout.
- Arithmetic: `issue_rem`/`deliver_rem` are LEN_W unsigned and never decrement below 0.

## Timing
- Reset values: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0, `err`=0; state IDLE, counters 0, skid empty.
- `fifo_rd_en` is combinational from state, `fifo_empty`, and `m_ready`. All other outputs are registered.
- Latency: `start` at cycle 0 → first `fifo_rd_en` at cycle 1 → `m_valid` at cycle 3 (FIFO latency plus skid register).
- With `m_ready` held high and the FIFO non-empty, one word per cycle.
- `done` asserts the cycle after the final handshake.
- Reset asserted mid-burst: all state clears immediately. In-flight FIFO data is discarded, and a `fifo_valid` seen with no read pending is ignored.

## Configuration
- `FIFO_RD_ERR_EN` defined:
  - `err` sets when `fifo_valid`=1 with no read pending.
  - `err` sets when a pending read sees `fifo_valid`=0.
  - `err` clears only on reset.
- `FIFO_RD_ERR_EN` undefined: the checking logic is absent and `err` is tied to 0.
- Data-path behaviour is identical in both builds.

## Structure
- Package `fifo_rd_pkg`:
  - state enum (IDLE/READ/FLUSH/DONE);
  - `SKID_DEPTH`=2;
  - `FIFO_RD_LAT`=1.
- Sub-module `fifo_rd_skid`: 2-entry valid/ready skid buffer exposing `occ`. The top level holds the FSM, counters, read-issue logic and error checker.

## Test plan
- FIFO preloaded with 0x01..0x0A, `len`=10, `m_ready`=1 → `m_data` 0x01..0x0A on 10 consecutive cycles starting cycle 3; `done` at cycle 13; `err`=0.
- Same data, `m_ready` toggling 1,0,1,0 → all 10 words in order, no duplicates; `occ` never exceeds 2; `fifo_rd_en` never asserted with `occ`+`inflight`=2 and no pop.
- FIFO holds 3 words, `len`=5; 2 more words written 20 cycles later → stall with `busy`=1 and no strobes while empty; 5 words delivered; `done` once.
- `len`=0 → `done` the cycle after `start`, no `fifo_rd_en`. Second `start` during a `len`=4 burst → ignored, exactly 4 words.
- Reset pulsed mid-burst after 3 of 8 words → all outputs at reset values; the next burst with `len`=2 returns the next 2 FIFO words.
- With `FIFO_RD_ERR_EN`: inject `fifo_valid` with no read pending → `err`=1 and sticky until reset. Without the macro, same stimulus → `err`=0.
